// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// Optional feature macro: FETCH_ALIGN_CHK_EN (adds HALT state and misalign flag).
package fetch_pkg;

    localparam int              XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] NOP     = 32'h0000_0013;

`ifdef FETCH_ALIGN_CHK_EN
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;
`endif

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue between the memory response port and the decoder.
// Power-of-two depth; pointers wrap naturally. Flush empties the queue and
// takes priority over a push or pop in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CW     = $clog2(QDEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(QDEPTH);

    fetch_entry_t    mem [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            pop_en;

    // A pop on an empty queue is ignored so the count can never underflow.
    assign pop_en = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Storage, pointers and occupancy; storage resets to zero so the decoder
    // sees a clean word/PC pair out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop_en);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited requests to
// instruction memory, in-order buffering of returned words, and redirect
// handling that flushes the queue and drains stale in-flight responses.
// Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned redirect -> HALT).
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic            fetch_misalign
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;        // next request address
    logic [XLEN-1:0] rsp_pc;    // PC of the next response that will be kept
    logic [CW-1:0]   inflight;  // accepted requests not yet answered (drop count in DRAIN)
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    q_push_data;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_dec;
    logic            rsp_keep;
    logic            q_pop;
    logic [XLEN-1:0] redirect_tgt;
    fetch_state_t    resume_state;

`ifdef FETCH_ALIGN_CHK_EN
    logic            misalign;
    logic            tgt_misalign;

    // Misaligned targets are loaded as-is and flagged.
    assign redirect_tgt   = redirect_pc;
    assign tgt_misalign   = |redirect_pc[1:0];
    assign fetch_misalign = misalign;

    // After a redirect (or the end of a drain) resume fetching unless the
    // current target is misaligned, in which case park in HALT.
    always_comb begin
        resume_state = ST_FETCH;
        if (redirect_valid ? tgt_misalign : misalign) begin
            resume_state = ST_HALT;
        end
    end
`else
    // Low address bits are discarded, so targets are always word aligned.
    assign redirect_tgt = redirect_pc & ~32'h3;
    assign resume_state = ST_FETCH;
`endif

    // Credit covers both words in flight and words already queued, so a
    // response always finds a free queue slot.
    assign credit_ok      = ({1'b0, inflight} + {1'b0, q_count}) < (CW + 1)'(QDEPTH);
    assign imem_req_valid = (state == ST_FETCH) && credit_ok && !redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses always retire one in-flight request; only those arriving in
    // FETCH without a concurrent redirect are kept.
    assign rsp_dec       = imem_rsp_valid && (inflight != '0);
    assign rsp_keep      = rsp_dec && (state == ST_FETCH) && !redirect_valid;
    assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_dec);

    assign q_pop       = if_valid && if_ready;
    assign q_push_data = '{pc: rsp_pc, inst: imem_rsp_data};

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .CW     (CW)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

    assign if_valid = (q_count != '0);
    assign if_inst  = q_head.inst;
    assign if_pc    = q_head.pc;

    // Fetch control: state, request PC, response PC tracking and in-flight count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RESET;
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
`ifdef FETCH_ALIGN_CHK_EN
            misalign <= 1'b0;
`endif
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                // Anything still in flight after this cycle is stale and must be drained.
                pc     <= redirect_tgt;
                rsp_pc <= redirect_tgt;
                state  <= (inflight_next != '0) ? ST_DRAIN : resume_state;
`ifdef FETCH_ALIGN_CHK_EN
                misalign <= tgt_misalign;
`endif
            end else begin
                case (state)
                    ST_RESET: state <= ST_FETCH;
                    ST_FETCH: begin
                        if (req_fire) begin
                            pc <= pc + PC_STEP;
                        end
                        if (rsp_keep) begin
                            rsp_pc <= rsp_pc + PC_STEP;
                        end
                    end
                    ST_DRAIN: begin
                        if (inflight_next == '0) begin
                            state <= resume_state;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a queue-based model of the
// instruction stream the decoder must see, plus a simple in-order memory.
// Define FETCH_ALIGN_CHK_EN to exercise the misalign/HALT feature.
module tb_inst_fetch_unit;

    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    inst_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit drop; }        infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; }         mreq_t;

    infl_t infl[$];   // model: requests issued and not yet answered
    ent_t  mq[$];     // model: words the decoder should see, in order
    mreq_t memq[$];   // memory: accepted requests awaiting response

    logic [31:0] mdl_pc = RESET_PC;
    bit          mis = 1'b0;
    bit          started = 1'b0;
    int          cyc = 0;

    int tests = 0;
    int fails = 0;

    // stimulus knobs
    bit          f_redir = 1'b0;
    logic [31:0] f_redir_pc = '0;
    int p_redir = 0, p_if_ready = 100, p_req_ready = 100, lat_min = 1, lat_extra = 0;

    // values sampled in the last step
    bit          s_req_valid, s_if_valid, s_mis;
    logic [31:0] s_req_addr, s_if_pc, s_if_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
`ifdef FETCH_ALIGN_CHK_EN
        if ($urandom_range(0, 9) != 0) r = r & ~32'h3;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive at edge+1, compare at edge+5, advance model at the edge.
    task automatic step();
        bit          rv, redir, rdy, ifr, exp_req, exp_ifv, anydrop, dreq;
        logic [31:0] tgt, daddr;
        infl_t       h;
        redir   = f_redir || ($urandom_range(0, 99) < p_redir);
        tgt     = f_redir ? f_redir_pc : rand_pc();
        f_redir = 1'b0;
        rdy     = ($urandom_range(0, 99) < p_req_ready);
        ifr     = ($urandom_range(0, 99) < p_if_ready);
        rv      = (memq.size() > 0) && (memq[0].due <= cyc);
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_req_ready = rdy;
        if_ready       = ifr;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? mem_word(memq[0].addr) : $urandom;
        #4;
        anydrop = 1'b0;
        foreach (infl[i]) if (infl[i].drop) anydrop = 1'b1;
        exp_req = started && !mis && !anydrop && !redir && ((infl.size() + mq.size()) < QDEPTH);
        exp_ifv = (mq.size() != 0);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        chk("req_addr", imem_req_addr, mdl_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, exp_ifv});
        if (exp_ifv) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_inst", if_inst, mq[0].inst);
        end
`ifdef FETCH_ALIGN_CHK_EN
        chk("misalign", {31'b0, fetch_misalign}, {31'b0, mis});
        s_mis = fetch_misalign;
`else
        s_mis = 1'b0;
`endif
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_if_valid  = if_valid;
        s_if_pc     = if_pc;
        s_if_inst   = if_inst;
        dreq  = imem_req_valid;
        daddr = imem_req_addr;
        @(posedge clk);
        if (rv) void'(memq.pop_front());
        if (dreq && rdy) memq.push_back('{addr: daddr, due: cyc + lat_min + $urandom_range(0, lat_extra)});
        if (exp_ifv && ifr) void'(mq.pop_front());
        if (rv && infl.size() > 0) begin
            h = infl.pop_front();
            if (!redir && !h.drop) mq.push_back('{pc: h.pc, inst: mem_word(h.pc)});
        end
        if (redir) begin
            mq.delete();
            foreach (infl[i]) infl[i].drop = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
            mdl_pc = tgt;
            mis    = (tgt[1:0] != 2'b00);
`else
            mdl_pc = tgt & ~32'h3;
`endif
        end else if (exp_req && rdy) begin
            infl.push_back('{pc: mdl_pc, drop: 1'b0});
            mdl_pc = mdl_pc + 32'd4;
        end
        started = 1'b1;
        cyc++;
        #1;
    endtask

    // Assert reset (asynchronously, mid-cycle), check reset values, release.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
`ifdef FETCH_ALIGN_CHK_EN
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        infl.delete();
        mq.delete();
        memq.delete();
        mdl_pc  = RESET_PC;
        mis     = 1'b0;
        started = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!s_req_valid && n < 40);
        if (!s_req_valid) begin
            tests++;
            fails++;
            $display("FAIL %s: no request within 40 cycles", name);
        end
    endtask

    initial begin
        logic [31:0] hold_pc;
        int n;
        @(posedge clk);
        #1;
        do_reset();

        // Straight-line fetch, 1-cycle memory.
        step(); chk("first_cycle_no_req", {31'b0, s_req_valid}, 32'd0);
        step(); chk("req0_valid", {31'b0, s_req_valid}, 32'd1);
                chk("req0_addr", s_req_addr, 32'h0);
        step(); chk("req1_addr", s_req_addr, 32'h4);
        step(); chk("first_if_valid", {31'b0, s_if_valid}, 32'd1);
                chk("first_if_pc", s_if_pc, 32'h0);
                chk("first_if_inst", s_if_inst, 32'hC0DE_0013);
        repeat (6) step();

        // Decoder backpressure for 10 cycles.
        p_if_ready = 0;
        step();
        hold_pc = s_if_pc;
        repeat (9) step();
        chk("bp_if_valid", {31'b0, s_if_valid}, 32'd1);
        chk("bp_req_stalled", {31'b0, s_req_valid}, 32'd0);
        chk("bp_if_pc_held", s_if_pc, hold_pc);
        p_if_ready = 100;
        repeat (10) step();

        // 3-cycle memory, redirect with responses outstanding.
        lat_min = 3;
        repeat (6) step();
        f_redir = 1'b1; f_redir_pc = 32'h100;
        step();
        n = 0;
        do begin step(); n++; end while (!s_if_valid && n < 40);
        chk("redir_first_pc", s_if_pc, 32'h100);
        chk("redir_first_inst", s_if_inst, 32'hC1DE_0013);

        // Redirect coincident with a response and request-ready.
        lat_min = 1;
        repeat (5) step();
        n = 0;
        while (!(memq.size() > 0 && memq[0].due <= cyc) && n < 20) begin step(); n++; end
        f_redir = 1'b1; f_redir_pc = 32'h100;
        step(); chk("coinc_no_req", {31'b0, s_req_valid}, 32'd0);
        step(); chk("coinc_next_req", {31'b0, s_req_valid}, 32'd1);
                chk("coinc_next_addr", s_req_addr, 32'h100);
        repeat (4) step();

        // PC wrap.
        f_redir = 1'b1; f_redir_pc = 32'hFFFF_FFFC;
        step();
        wait_req("wrap_a"); chk("wrap_addr_a", s_req_addr, 32'hFFFF_FFFC);
        wait_req("wrap_b"); chk("wrap_addr_b", s_req_addr, 32'h0);
        repeat (4) step();

`ifdef FETCH_ALIGN_CHK_EN
        // Misaligned redirect halts fetch until an aligned redirect.
        f_redir = 1'b1; f_redir_pc = 32'h102;
        step();
        repeat (4) begin
            step();
            chk("mis_flag", {31'b0, s_mis}, 32'd1);
            chk("mis_no_req", {31'b0, s_req_valid}, 32'd0);
        end
        f_redir = 1'b1; f_redir_pc = 32'h200;
        step();
        wait_req("mis_resume");
        chk("mis_resume_addr", s_req_addr, 32'h200);
        chk("mis_cleared", {31'b0, s_mis}, 32'd0);
        repeat (4) step();
`endif

        // Reset in the middle of traffic.
        do_reset();
        step(); chk("rerst_no_req", {31'b0, s_req_valid}, 32'd0);
        step(); chk("rerst_req_addr", s_req_addr, RESET_PC);

        // Randomized traffic.
        p_redir = 3; p_if_ready = 70; p_req_ready = 70; lat_min = 1; lat_extra = 3;
        repeat (3000) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
